mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl_if.sv | 24 ++
 rtl/mdu_ctrl.sv | 140 ++++++++++++++
 tb/tb_mdu_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_ctrl_if.sv
// Pipeline <-> multiply/divide unit handshake bundle.
// The master side is the EX stage; the slave side is mdu_ctrl.
interface mdu_ctrl_if;
    logic        md_valid;
    logic [2:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        mf_req;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        done;

    modport master (
        output md_valid, md_op, rs_val, rt_val, mf_req,
        input  busy, stall, hi, lo, done
    );

    modport slave (
        input  md_valid, md_op, rs_val, rt_val, mf_req,
        output busy, stall, hi, lo, done
    );
endinterface

// File: rtl/mdu_ctrl.sv
// Multi-cycle mult/div controller owning the HI/LO registers and the pipeline stall.
// Define MDU_DIV_EN to include div/divu; otherwise those opcodes are no-ops.
//
// state  | meaning
// IDLE   | no operation in flight; accepts mult/div, applies mthi/mtlo
// MUL    | mult/multu counting down 5 cycles
// DIV    | div/divu counting down 10 cycles (MDU_DIV_EN only)
module mdu_ctrl (
    input  logic   clk,
    input  logic   reset,
    mdu_ctrl_if.slave bus
);
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

`ifdef MDU_DIV_EN
    localparam logic [2:0] OP_DIVU  = 3'b100;
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;
`else
    typedef enum logic {S_IDLE, S_MUL} state_t;
`endif

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        sgn_q, sgn_d;
    logic        done_q, done_d;

    logic        idle, is_mul, accept;
    logic [63:0] a_ext, b_ext, prod;

    assign idle   = (state_q == S_IDLE);
    assign is_mul = (bus.md_op == OP_MULT) | (bus.md_op == OP_MULTU);

    // Sign/zero extension to 64 bits makes one unsigned multiplier serve both forms.
    assign a_ext = {{32{sgn_q & a_q[31]}}, a_q};
    assign b_ext = {{32{sgn_q & b_q[31]}}, b_q};
    assign prod  = a_ext * b_ext;

`ifdef MDU_DIV_EN
    logic        is_div, a_neg, b_neg;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, quo, rem;

    assign is_div = (bus.md_op == OP_DIV) | (bus.md_op == OP_DIVU);
    assign accept = bus.md_valid & idle & (is_mul | is_div);

    // Divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 instead of overflowing.
    assign a_neg = sgn_q & a_q[31];
    assign b_neg = sgn_q & b_q[31];
    assign a_mag = a_neg ? (32'd0 - a_q) : a_q;
    assign b_mag = b_neg ? (32'd0 - b_q) : b_q;
    assign q_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
    assign r_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag % b_mag);
    assign quo   = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    assign rem   = a_neg ? (32'd0 - r_mag) : r_mag;
`else
    assign accept = bus.md_valid & idle & is_mul;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    a_d     = bus.rs_val;
                    b_d     = bus.rt_val;
                    sgn_d   = (bus.md_op == OP_MULT) | (bus.md_op == OP_DIV);
                    state_d = S_MUL;
                    cnt_d   = 4'd5;
`ifdef MDU_DIV_EN
                    if (is_div) begin
                        state_d = S_DIV;
                        cnt_d   = 4'd10;
                    end
`endif
                end else if (bus.md_valid && bus.md_op == OP_MTHI) begin
                    hi_d = bus.rs_val;
                end else if (bus.md_valid && bus.md_op == OP_MTLO) begin
                    lo_d = bus.rs_val;
                end
            end
            default: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    if (state_q == S_MUL) begin
                        hi_d = prod[63:32];
                        lo_d = prod[31:0];
                    end
`ifdef MDU_DIV_EN
                    else if (b_q != 32'd0) begin
                        hi_d = rem;
                        lo_d = quo;
                    end
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            sgn_q   <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy  = ~idle;
    assign bus.stall = (bus.md_valid & ~idle) | (bus.mf_req & (~idle | accept));
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: stimulus pushes expected {HI,LO}, a monitor pops on done.
// Builds with or without MDU_DIV_EN and expects matching div/divu behaviour.
module tb_mdu_ctrl;
    logic clk = 1'b0;
    logic reset;

    mdu_ctrl_if bus();
    mdu_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [63:0] exp_q[$];
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;
    logic [63:0] mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] h, input logic [31:0] l);
        exp_q.push_back({h, l});
        exp_hi = h;
        exp_lo = l;
    endtask

    // Issues one op, scrambles operands after accept, returns at the first idle negedge.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] rs,
                          input logic [31:0] rt, input int exp_busy);
        int n;
        n = 0;
        step();
        bus.md_valid = 1'b1;
        bus.md_op    = op;
        bus.rs_val   = rs;
        bus.rt_val   = rt;
        @(negedge clk);
        check({name, "_stall_pre"}, 64'(bus.stall), 64'd0);
        step();
        bus.md_valid = 1'b0;
        bus.md_op    = 3'b000;
        bus.rs_val   = ~rs;
        bus.rt_val   = ~rt;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
            n++;
        end
        check({name, "_busy_cycles"}, 64'(n), 64'(exp_busy));
    endtask

    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("done_unexpected", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("hilo_result", {bus.hi, bus.lo}, mon_e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int ns;
        reset        = 1'b1;
        bus.md_valid = 1'b0;
        bus.md_op    = 3'b000;
        bus.rs_val   = 32'd0;
        bus.rt_val   = 32'd0;
        bus.mf_req   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy",  64'(bus.busy),  64'd0);
        check("rst_stall", 64'(bus.stall), 64'd0);
        check("rst_done",  64'(bus.done),  64'd0);
        check("rst_hilo",  {bus.hi, bus.lo}, 64'd0);

        push(32'hFFFFFFFF, 32'hFFFFFFFA);
        run_op("mult", 3'b001, 32'hFFFFFFFE, 32'd3, 5);
        push(32'hFFFFFFFE, 32'h00000001);
        run_op("multu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5);
        push(32'hFFFFFFFF, 32'hFFFFFFEB);
        run_op("mult_neg", 3'b001, 32'd7, 32'hFFFFFFFD, 5);
        push(32'h00000001, 32'h00000000);
        run_op("multu_2p32", 3'b010, 32'h00010000, 32'h00010000, 5);

`ifdef MDU_DIV_EN
        push(32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div", 3'b011, 32'hFFFFFFF9, 32'd2, 10);
        push(exp_hi, exp_lo);
        run_op("divu_zero", 3'b100, 32'd7, 32'd0, 10);
        push(32'h00000000, 32'h80000000);
        run_op("div_ovf", 3'b011, 32'h80000000, 32'hFFFFFFFF, 10);
        push(32'd2, 32'd14);
        run_op("divu", 3'b100, 32'd100, 32'd7, 10);
`else
        run_op("div_noop", 3'b011, 32'hFFFFFFF9, 32'd2, 0);
        run_op("divu_noop", 3'b100, 32'd7, 32'd0, 0);
`endif
        check("hilo_hold", {bus.hi, bus.lo}, {exp_hi, exp_lo});

        // mthi / mtlo while idle
        step();
        bus.md_valid = 1'b1; bus.md_op = 3'b101; bus.rs_val = 32'hAAAA5555;
        step();
        bus.md_op = 3'b110; bus.rs_val = 32'h5A5A0F0F;
        @(negedge clk);
        check("mthi_hi",   64'(bus.hi),   64'h00000000AAAA5555);
        check("mthi_busy", 64'(bus.busy), 64'd0);
        step();
        bus.md_valid = 1'b0; bus.md_op = 3'b000;
        @(negedge clk);
        check("mtlo_hilo", {bus.hi, bus.lo}, {32'hAAAA5555, 32'h5A5A0F0F});

        // mult immediately followed by mfhi/mflo
        step();
        bus.md_valid = 1'b1; bus.md_op = 3'b001; bus.rs_val = 32'd3; bus.rt_val = 32'd5;
        bus.mf_req = 1'b1;
        push(32'd0, 32'd15);
        @(negedge clk);
        check("mf_stall_accept", 64'(bus.stall), 64'd1);
        step();
        bus.md_valid = 1'b0; bus.md_op = 3'b000;
        n = 0; ns = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
            n++;
            if (bus.stall) ns++;
        end
        check("mf_busy_cycles",  64'(n),  64'd5);
        check("mf_stall_cycles", 64'(ns), 64'd5);
        check("mf_stall_idle",   64'(bus.stall), 64'd0);
        check("mf_read_hilo",    {bus.hi, bus.lo}, {32'd0, 32'd15});
        step();
        bus.mf_req = 1'b0;

        // back-to-back mult held while busy, then mthi held while busy
        bus.md_valid = 1'b1; bus.md_op = 3'b001; bus.rs_val = 32'd2; bus.rt_val = 32'd2;
        push(32'd0, 32'd4);
        step();
        bus.rs_val = 32'd6; bus.rt_val = 32'd7;
        n = 0; ns = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
            n++;
            if (bus.stall) ns++;
        end
        check("b2b_busy1",  64'(n),  64'd5);
        check("b2b_stall1", 64'(ns), 64'd5);
        check("b2b_idle_stall", 64'(bus.stall), 64'd0);
        push(32'd0, 32'd42);
        step();
        bus.md_op = 3'b101; bus.rs_val = 32'hDEADBEEF;
        n = 0; ns = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
            n++;
            if (bus.stall) ns++;
        end
        check("b2b_busy2",  64'(n),  64'd5);
        check("mthi_busy_stall", 64'(ns), 64'd5);
        check("mthi_deferred_hilo", {bus.hi, bus.lo}, {32'd0, 32'd42});
        step();
        bus.md_valid = 1'b0; bus.md_op = 3'b000;
        @(negedge clk);
        check("mthi_applied", {bus.hi, bus.lo}, {32'hDEADBEEF, 32'd42});
        check("mthi_applied_busy", 64'(bus.busy), 64'd0);

        // mf_req while idle with nothing accepted
        step();
        bus.mf_req = 1'b1;
        @(negedge clk);
        check("mf_idle_stall", 64'(bus.stall), 64'd0);
        check("mf_idle_hi",    64'(bus.hi),    64'h00000000DEADBEEF);
        step();
        bus.mf_req = 1'b0;

        // reset in the third busy cycle aborts the operation
`ifdef MDU_DIV_EN
        bus.md_op = 3'b011; bus.rs_val = 32'd100; bus.rt_val = 32'd7;
`else
        bus.md_op = 3'b001; bus.rs_val = 32'd3; bus.rt_val = 32'd3;
`endif
        bus.md_valid = 1'b1;
        step();
        bus.md_valid = 1'b0; bus.md_op = 3'b000;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_hilo", {bus.hi, bus.lo}, 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);

        step();
        bus.md_valid = 1'b1; bus.md_op = 3'b110; bus.rs_val = 32'h00001234;
        step();
        bus.md_valid = 1'b0; bus.md_op = 3'b000;
        @(negedge clk);
        check("mtlo_after_abort", {bus.hi, bus.lo}, {32'd0, 32'h00001234});
        check("mtlo_after_abort_busy", 64'(bus.busy), 64'd0);

        // reset wins over mthi and over accept in the same cycle
        step();
        bus.md_valid = 1'b1; bus.md_op = 3'b101; bus.rs_val = 32'hFFFF0000;
        reset = 1'b1;
        step();
        bus.md_op = 3'b001; bus.rs_val = 32'd5; bus.rt_val = 32'd5;
        step();
        reset = 1'b0; bus.md_valid = 1'b0; bus.md_op = 3'b000;
        @(negedge clk);
        check("rst_prio_hilo", {bus.hi, bus.lo}, 64'd0);
        check("rst_prio_busy", 64'(bus.busy), 64'd0);

        repeat (15) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
